mmio_port_bank: RTL

- Parametrised memory-mapped I/O bank on the CPU memory bus; replaces per-address LED/switch decode glue.
- NCH channels, each with one output register and one synchronised input with rising-edge capture.
- Address decode and read-data drive are internal. rd_hit tells the top-level mux when to select rd_data onto mdata.
- Adds readback, edge latching with write-1-to-clear, atomic toggle and an interrupt summary.

---
 rtl/mmio_pkg.sv | 16 +
 rtl/mmio_port_bank_if.sv | 19 +
 rtl/mmio_channel.sv | 54 +++++
 rtl/mmio_port_bank.sv | 112 +++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped port bank.
//   mem_cmd_t : 2-bit CPU bus command (MWRITE, MREAD; other codes idle)
//   OFF_*     : register offsets within a channel's 4-address slot
package mmio_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t MWRITE = 2'b01;
  localparam mem_cmd_t MREAD  = 2'b11;

  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_TGL  = 2'd3;

endpackage

// File: rtl/mmio_port_bank_if.sv
// CPU memory bus as seen by the port bank.
//   mem_addr, mem_cmd, wr_data : driven by the CPU (master)
//   rd_data, rd_hit            : driven by the bank (slave); the top-level
//                                mux selects rd_data onto mdata when rd_hit=1
interface mmio_port_bank_if #(
  parameter int ADDR_W = 10
) ();
  import mmio_pkg::*;

  logic [ADDR_W-1:0] mem_addr;
  mem_cmd_t          mem_cmd;
  logic [15:0]       wr_data;
  logic [15:0]       rd_data;
  logic              rd_hit;

  modport master (output mem_addr, mem_cmd, wr_data, input rd_data, rd_hit);
  modport slave  (input mem_addr, mem_cmd, wr_data, output rd_data, rd_hit);

endinterface

// File: rtl/mmio_channel.sv
// One I/O channel: output register, input synchroniser, edge detector and
// sticky EDGE register with write-1-to-clear.
//   wr_out / wr_tgl / wr_clr : decoded write strobes (load, XOR, W1C)
//   wr_data                  : low DW bits of the CPU write data
//   prime_done               : enables rise detection once the chain is primed
//   pin                      : asynchronous input pins
//   out_q, in_q, edge_q      : OUT register, synchronised input, EDGE register
module mmio_channel
  import mmio_pkg::*;
#(
  parameter int DW          = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_out,
  input  logic          wr_tgl,
  input  logic          wr_clr,
  input  logic [DW-1:0] wr_data,
  input  logic          prime_done,
  input  logic [DW-1:0] pin,
  output logic [DW-1:0] out_q,
  output logic [DW-1:0] in_q,
  output logic [DW-1:0] edge_q
);

  logic [DW-1:0] sync_p [SYNC_STAGES];
  logic [DW-1:0] prev_q;
  logic [DW-1:0] rise;
  logic [DW-1:0] clr_mask;

  assign in_q     = sync_p[SYNC_STAGES-1];
  assign rise     = prime_done ? (in_q & ~prev_q) : '0;
  assign clr_mask = wr_clr ? wr_data : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_p[i] <= '0;
      prev_q <= '0;
      edge_q <= '0;
      out_q  <= '0;
    end else begin
      // synchroniser chain -> prev stage -> sticky edge register
      sync_p[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) sync_p[i] <= sync_p[i-1];
      prev_q <= in_q;
      // OR-ing rise after the clear lets a new edge win over a same-cycle W1C
      edge_q <= (edge_q & ~clr_mask) | rise;
      if (wr_out)      out_q <= wr_data;
      else if (wr_tgl) out_q <= out_q ^ wr_data;
    end
  end

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O bank: NCH channels of DW bits, each occupying four
// addresses (OUT, IN, EDGE, TGL) starting at ADDR_BASE.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : CPU memory bus (slave side); reads are combinational
//   in_pins      : asynchronous inputs, channel c at [c*DW +: DW]
//   out_pins     : output registers, same packing
//   irq          : OR of every EDGE bit
module mmio_port_bank
  import mmio_pkg::*;
#(
  parameter int                NCH         = 2,
  parameter int                DW          = 8,
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] ADDR_BASE   = 'h100,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  mmio_port_bank_if.slave       bus,
  input  logic [NCH*DW-1:0]     in_pins,
  output logic [NCH*DW-1:0]     out_pins,
  output logic                  irq
);

  localparam int                PW         = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0]     PRIME_LAST = PW'(SYNC_STAGES + 1);
  localparam logic [ADDR_W-1:0] NCH_A      = ADDR_W'(NCH);

  logic [ADDR_W-1:0] rel_addr;
  logic [ADDR_W-1:0] ch_idx;
  logic [1:0]        off;
  logic              in_win;
  logic              wr_en;

  // A wrapped subtraction for addresses below the base is rejected by the
  // explicit >= compare, so the channel index alone need not catch it.
  assign rel_addr   = bus.mem_addr - ADDR_BASE;
  assign off        = rel_addr[1:0];
  assign ch_idx     = {2'b00, rel_addr[ADDR_W-1:2]};
  assign in_win     = (bus.mem_addr >= ADDR_BASE) && (ch_idx < NCH_A);
  assign wr_en      = (bus.mem_cmd == MWRITE) && in_win;
  assign bus.rd_hit = (bus.mem_cmd == MREAD) && in_win;

  // Shared priming counter: rise detection stays off until the synchroniser
  // and prev flops hold real pin samples, so pins high through reset are
  // not reported as edges.
  logic [PW-1:0] prime_cnt;
  logic          prime_done;

  assign prime_done = (prime_cnt == PRIME_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        prime_cnt <= '0;
    else if (!prime_done) prime_cnt <= prime_cnt + 1'b1;
  end

  logic [DW-1:0]     out_q  [NCH];
  logic [DW-1:0]     in_q   [NCH];
  logic [DW-1:0]     edge_q [NCH];
  logic [NCH*DW-1:0] edge_all;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (ch_idx == ADDR_W'(c));

    mmio_channel #(
      .DW          (DW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .wr_out     (sel && (off == OFF_OUT)),
      .wr_tgl     (sel && (off == OFF_TGL)),
      .wr_clr     (sel && (off == OFF_EDGE)),
      .wr_data    (bus.wr_data[DW-1:0]),
      .prime_done (prime_done),
      .pin        (in_pins[c*DW +: DW]),
      .out_q      (out_q[c]),
      .in_q       (in_q[c]),
      .edge_q     (edge_q[c])
    );

    assign out_pins[c*DW +: DW] = out_q[c];
    assign edge_all[c*DW +: DW] = edge_q[c];
  end

  assign irq = |edge_all;

  logic [DW-1:0] rd_field;

  always_comb begin
    rd_field = '0;
    for (int c = 0; c < NCH; c++) begin
      if (ch_idx == ADDR_W'(c)) begin
        case (off)
          OFF_OUT:  rd_field = out_q[c];
          OFF_IN:   rd_field = in_q[c];
          OFF_EDGE: rd_field = edge_q[c];
          default:  rd_field = '0;
        endcase
      end
    end
  end

  assign bus.rd_data = bus.rd_hit ? 16'(rd_field) : 16'h0000;

  if (DW < 16) begin : g_unused
    logic unused_wr_hi;
    assign unused_wr_hi = ^bus.wr_data[15:DW];
  end

endmodule
